// File: rtl/ps2_rx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_rx_fifo_if
//  Purpose  : Read-side bus between the PS/2 receive FIFO and the CPU
//             peripheral bus. It carries the pop strobe, head byte, fill level
//             and the sticky error flags with their clear strobe.
//  Revision : 1.0  initial release
// ============================================================================
interface ps2_rx_fifo_if #(
  parameter int FIFO_DEPTH_LOG2 = 3
);
  logic                     rd_en;
  logic [7:0]               rd_data;
  logic                     rd_valid;
  logic [FIFO_DEPTH_LOG2:0] fifo_count;
  logic                     parity_err;
  logic                     frame_err;
  logic                     overflow;
  logic                     err_clear;

  // CPU / bus side
  modport master (
    output rd_en, err_clear,
    input  rd_data, rd_valid, fifo_count, parity_err, frame_err, overflow
  );

  // Receiver side
  modport slave (
    input  rd_en, err_clear,
    output rd_data, rd_valid, fifo_count, parity_err, frame_err, overflow
  );
endinterface
`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_rx_fifo
//  Purpose  : PS/2 device-to-host receiver. It synchronises and filters the
//             pins, decodes 11-bit frames, checks odd parity, recovers from
//             timeouts and buffers good bytes in a small circular FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module ps2_rx_fifo #(
  parameter int SYSCLK_FREQUENCY = 1000,  // system clock in units of 100 kHz
  parameter int FILTER_LEN       = 8,     // 2..255 stable cycles
  parameter int FIFO_DEPTH_LOG2  = 3
) (
  input  wire logic   clk,
  input  wire logic   reset_in,
  input  wire logic   ps2_clk_in,
  input  wire logic   ps2_dat_in,
  ps2_rx_fifo_if.slave bus
);
  localparam int c_DEPTH   = 2 ** FIFO_DEPTH_LOG2;
  localparam int c_CW      = FIFO_DEPTH_LOG2 + 1;
  localparam int c_PW      = FIFO_DEPTH_LOG2;
  localparam int c_TIMEOUT = SYSCLK_FREQUENCY * 200;
  localparam int c_TO_W    = $clog2(c_TIMEOUT + 1);
  localparam logic [7:0]        c_FILT_LAST = 8'(FILTER_LEN - 1);
  localparam logic [c_TO_W-1:0] c_TO_LAST   = c_TO_W'(c_TIMEOUT - 1);
  localparam logic [c_CW-1:0]   c_FULL      = c_CW'(c_DEPTH);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RECV = 1'b1} state_t;

  logic r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic r_filt_clk, r_filt_prev;
  logic [7:0] r_filt_cnt;
  logic w_fall;

  state_t            r_state, w_state_nx;
  logic [3:0]        r_bitcnt, w_bitcnt_nx;
  logic [7:0]        r_shreg, w_shreg_nx;
  logic              r_par, w_par_nx;
  logic [c_TO_W-1:0] r_to_cnt, w_to_nx;
  logic              w_push, w_frame_evt, w_parity_evt, w_par_ok;
  logic              r_push;
  logic [7:0]        r_push_data;

  logic [7:0]      r_mem [c_DEPTH];
  logic [c_PW-1:0] r_wr_ptr, r_rd_ptr, w_rd_ptr_nx;
  logic [c_CW-1:0] r_count, w_count_after_pop, w_count_nx;
  logic [7:0]      r_rd_data;
  logic            r_rd_valid;
  logic            w_empty, w_full, w_pop, w_wr, w_ovf_evt;
  logic            r_parity_err, r_frame_err, r_overflow;

  // Two-flop synchronisers for both asynchronous pins (idle level is high)
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk_in;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_dat_in;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Glitch filter: accept a new clock level only after FILTER_LEN stable cycles
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      r_filt_clk  <= 1'b1;
      r_filt_prev <= 1'b1;
      r_filt_cnt  <= '0;
    end else begin
      r_filt_prev <= r_filt_clk;
      if (r_clk_s2 == r_filt_clk) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == c_FILT_LAST) begin
        r_filt_clk <= r_clk_s2;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 8'd1;
      end
    end
  end

  assign w_fall   = r_filt_prev & ~r_filt_clk;
  assign w_par_ok = ^{r_shreg, r_par};

  // Frame decoder state register plus the registered push request
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      r_state     <= S_IDLE;
      r_bitcnt    <= '0;
      r_shreg     <= '0;
      r_par       <= 1'b0;
      r_to_cnt    <= '0;
      r_push      <= 1'b0;
      r_push_data <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_bitcnt    <= w_bitcnt_nx;
      r_shreg     <= w_shreg_nx;
      r_par       <= w_par_nx;
      r_to_cnt    <= w_to_nx;
      r_push      <= w_push;
      r_push_data <= r_shreg;
    end
  end

  // Frame decoder next-state: start, 8 data bits LSB first, parity, stop
  always_comb begin
    w_state_nx   = r_state;
    w_bitcnt_nx  = r_bitcnt;
    w_shreg_nx   = r_shreg;
    w_par_nx     = r_par;
    w_to_nx      = r_to_cnt;
    w_push       = 1'b0;
    w_frame_evt  = 1'b0;
    w_parity_evt = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_to_nx = '0;
        if (w_fall) begin
          if (!r_dat_s2) begin
            w_state_nx  = S_RECV;
            w_bitcnt_nx = 4'd1;
          end else begin
            w_frame_evt = 1'b1;
          end
        end
      end
      S_RECV: begin
        if (w_fall) begin
          w_to_nx = '0;
          if (r_bitcnt <= 4'd8) begin
            w_shreg_nx  = {r_dat_s2, r_shreg[7:1]};
            w_bitcnt_nx = r_bitcnt + 4'd1;
          end else if (r_bitcnt == 4'd9) begin
            w_par_nx    = r_dat_s2;
            w_bitcnt_nx = 4'd10;
          end else begin
            w_state_nx  = S_IDLE;
            w_bitcnt_nx = '0;
            // A bad stop bit is reported as a framing error regardless of parity
            if (!r_dat_s2)     w_frame_evt  = 1'b1;
            else if (w_par_ok) w_push       = 1'b1;
            else               w_parity_evt = 1'b1;
          end
        end else if (r_to_cnt == c_TO_LAST) begin
          w_frame_evt = 1'b1;
          w_state_nx  = S_IDLE;
          w_bitcnt_nx = '0;
          w_to_nx     = '0;
        end else begin
          w_to_nx = r_to_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nx  = S_IDLE;
        w_bitcnt_nx = '0;
      end
    endcase
  end

  assign w_empty           = (r_count == '0);
  assign w_full            = (r_count == c_FULL);
  assign w_pop             = bus.rd_en & ~w_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO succeeds
  assign w_wr              = r_push & (~w_full | w_pop);
  assign w_ovf_evt         = r_push & w_full & ~w_pop;
  assign w_rd_ptr_nx       = r_rd_ptr + c_PW'(w_pop);
  assign w_count_after_pop = r_count - c_CW'(w_pop);
  assign w_count_nx        = w_count_after_pop + c_CW'(w_wr);

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_push_data;
  end

  // FIFO pointers, fill level and the registered head byte / valid
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_wr_ptr   <= r_wr_ptr + c_PW'(w_wr);
      r_rd_ptr   <= w_rd_ptr_nx;
      r_count    <= w_count_nx;
      r_rd_valid <= (w_count_nx != '0);
      // The byte being written becomes the head when nothing older remains
      if (w_wr && (w_count_after_pop == '0)) r_rd_data <= r_push_data;
      else if (w_count_after_pop != '0)     r_rd_data <= r_mem[w_rd_ptr_nx];
    end
  end

  // Sticky error flags: a new event outranks a simultaneous clear
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_parity_err <= w_parity_evt | (r_parity_err & ~bus.err_clear);
      r_frame_err  <= w_frame_evt  | (r_frame_err  & ~bus.err_clear);
      r_overflow   <= w_ovf_evt    | (r_overflow   & ~bus.err_clear);
    end
  end

  assign bus.rd_data    = r_rd_data;
  assign bus.rd_valid   = r_rd_valid;
  assign bus.fifo_count = r_count;
  assign bus.parity_err = r_parity_err;
  assign bus.frame_err  = r_frame_err;
  assign bus.overflow   = r_overflow;
endmodule
`default_nettype wire
